jt12_wrq: RTL and testbench

JT12_WRQ -- requirements
Module: jt12_wrq

---
 rtl/jt12_wrq.sv | 208 ++++++++++++++++++++
 tb/tb_jt12_wrq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt12_wrq.sv
// Host register-write queue for a YM2612-style chip bus: FIFO plus address/data strobe sequencer.
// Optional BUSY_W timeout with sticky tmo output when JT12_WRQ_TIMEOUT_EN is defined.
module jt12_wrq #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WR_LEN = 2,
  parameter int unsigned GUARD  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cen,
  input  logic                   host_wr,
  input  logic                   host_port,
  input  logic [7:0]             host_reg,
  input  logic [7:0]             host_val,
  output logic                   host_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf,
  output logic                   cs_n,
  output logic                   wr_n,
  output logic [1:0]             addr,
  output logic [7:0]             din,
  input  logic [7:0]             dout
`ifdef JT12_WRQ_TIMEOUT_EN
  ,
  output logic                   tmo
`endif
);

  localparam int unsigned Aw = $clog2(DEPTH);
  localparam int unsigned Lw = Aw + 1;
  localparam logic [3:0] WrLenM1 = 4'(WR_LEN - 1);
  localparam logic [3:0] GuardM1 = 4'(GUARD - 1);

  typedef enum logic [2:0] {StIdle, StAStb, StAGap, StDStb, StGuard, StBusy} state_e;

  // Reset asserts asynchronously; release is taken up one edge later so all state leaves reset
  // on the same clock.
  logic rst_sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 1'b0;
    else        rst_sync_q <= 1'b1;
  end

  logic [16:0]   mem_q [DEPTH];
  logic [Aw-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [Lw-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          full, push, pop;
  logic [16:0]   head;

  assign full = (level_q == Lw'(DEPTH));
  assign push = rst_sync_q & host_wr & ~full;
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + Aw'(push);
    rd_ptr_d = rd_ptr_q + Aw'(pop);
    level_d  = level_q + Lw'(push) - Lw'(pop);
    ovf_d    = ovf_q | (host_wr & full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (rst_sync_q) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {host_port, host_reg, host_val};
  end

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       stb_n_q, stb_n_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] din_q, din_d;
  logic [7:0] val_q, val_d;
`ifdef JT12_WRQ_TIMEOUT_EN
  logic [9:0] tmo_cnt_q, tmo_cnt_d;
  logic       tmo_q, tmo_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stb_n_d = stb_n_q;
    addr_d  = addr_q;
    din_d   = din_q;
    val_d   = val_q;
    pop     = 1'b0;
`ifdef JT12_WRQ_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    tmo_d     = tmo_q;
`endif
    if (cen) begin
      unique case (state_q)
        StIdle: begin
          if (level_q != '0) begin
            pop     = 1'b1;
            state_d = StAStb;
            addr_d  = {head[16], 1'b0};
            din_d   = head[15:8];
            val_d   = head[7:0];
            stb_n_d = 1'b0;
            cnt_d   = WrLenM1;
          end
        end
        StAStb: begin
          if (cnt_q == '0) begin
            state_d = StAGap;
            stb_n_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        StAGap: begin
          state_d = StDStb;
          addr_d  = {addr_q[1], 1'b1};
          din_d   = val_q;
          stb_n_d = 1'b0;
          cnt_d   = WrLenM1;
        end
        StDStb: begin
          if (cnt_q == '0) begin
            state_d = StGuard;
            stb_n_d = 1'b1;
            cnt_d   = GuardM1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        StGuard: begin
          if (cnt_q == '0) begin
            state_d = StBusy;
`ifdef JT12_WRQ_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        StBusy: begin
          if (!dout[7]) begin
            state_d = StIdle;
          end
`ifdef JT12_WRQ_TIMEOUT_EN
          else if (tmo_cnt_q == 10'd1022) begin
            state_d = StIdle;
            tmo_d   = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 10'd1;
          end
`endif
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      stb_n_q <= 1'b1;
      addr_q  <= '0;
      din_q   <= '0;
      val_q   <= '0;
`ifdef JT12_WRQ_TIMEOUT_EN
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
`endif
    end else if (rst_sync_q) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stb_n_q <= stb_n_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      val_q   <= val_d;
`ifdef JT12_WRQ_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
`endif
    end
  end

  logic unused_dout;
  assign unused_dout = ^dout[6:0];

  assign host_ready = ~full;
  assign level      = level_q;
  assign ovf        = ovf_q;
  assign cs_n       = stb_n_q;
  assign wr_n       = stb_n_q;
  assign addr       = addr_q;
  assign din        = din_q;
`ifdef JT12_WRQ_TIMEOUT_EN
  assign tmo        = tmo_q;
`endif

endmodule

// File: tb/tb_jt12_wrq.sv
// Scoreboard bench for jt12_wrq: each accepted push predicts an address strobe and a data strobe.
module tb_jt12_wrq;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned WR_LEN = 2;
  localparam int unsigned GUARD  = 4;

  logic       clk = 1'b0;
  logic       rst_n, cen, host_wr, host_port, host_ready, ovf, cs_n, wr_n;
  logic [7:0] host_reg, host_val, din, dout;
  logic [1:0] addr;
  logic [$clog2(DEPTH):0] level;
`ifdef JT12_WRQ_TIMEOUT_EN
  logic tmo;
`endif

  always #5 clk = ~clk;

  jt12_wrq #(.DEPTH(DEPTH), .WR_LEN(WR_LEN), .GUARD(GUARD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .host_wr    (host_wr),
    .host_port  (host_port),
    .host_reg   (host_reg),
    .host_val   (host_val),
    .host_ready (host_ready),
    .level      (level),
    .ovf        (ovf),
    .cs_n       (cs_n),
    .wr_n       (wr_n),
    .addr       (addr),
    .din        (din),
    .dout       (dout)
`ifdef JT12_WRQ_TIMEOUT_EN
    ,
    .tmo        (tmo)
`endif
  );

  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
  } stb_t;

  stb_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cen_div = 1;
  int   cen_ph = 0;
  bit   cen_run = 1'b0;
  bit   busy_force = 1'b0;
  bit   busy_rand_en = 1'b0;
  bit   busy_rnd = 1'b0;

  assign dout = {busy_force | (busy_rand_en & busy_rnd), 7'd0};

  task automatic report(input string nm, input bit ok, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, req, req);
    end
  endtask

  // cen is high on one clock in every cen_div
  initial begin
    cen = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cen_ph = (cen_ph + 1 >= cen_div) ? 0 : cen_ph + 1;
      cen    = cen_run && (cen_ph == 0);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      busy_rnd = ($urandom_range(0, 3) == 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Monitor: measure each strobe and its preceding high gap in clk cycles
  bit         in_stb = 1'b0;
  bit         have_prev = 1'b0;
  bit         s_bad;
  int         lo_cnt, s_gap;
  int         hi_cnt = 0;
  int         nstb = 0;
  logic [1:0] s_addr;
  logic [7:0] s_din;

  task automatic end_strobe();
    stb_t e;
    if (exp_q.size() == 0) begin
      report("unexpected_strobe", 1'b0, int'(s_addr), 0);
      return;
    end
    e = exp_q.pop_front();
    report("strobe_addr", s_addr == e.a, int'(s_addr), int'(e.a));
    report("strobe_din", s_din == e.d, int'(s_din), int'(e.d));
    report("strobe_width", lo_cnt == WR_LEN * cen_div, lo_cnt, WR_LEN * cen_div);
    report("strobe_stable", !s_bad, int'(s_bad), 0);
    if (e.a[0]) report("addr_data_gap", s_gap == cen_div, s_gap, cen_div);
    else if (have_prev)
      report("write_spacing", s_gap >= (GUARD + 2) * cen_div, s_gap, (GUARD + 2) * cen_div);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      in_stb    = 1'b0;
      have_prev = 1'b0;
      hi_cnt    = 0;
      exp_q.delete();
    end else if (cs_n === 1'b0) begin
      if (!in_stb) begin
        in_stb = 1'b1;
        nstb++;
        lo_cnt = 0;
        s_addr = addr;
        s_din  = din;
        s_gap  = hi_cnt;
        s_bad  = 1'b0;
      end
      lo_cnt++;
      if (wr_n !== 1'b0 || addr !== s_addr || din !== s_din) s_bad = 1'b1;
    end else begin
      if (in_stb) begin
        in_stb = 1'b0;
        end_strobe();
        hi_cnt    = 0;
        have_prev = 1'b1;
      end
      if (hi_cnt < 100000) hi_cnt++;
    end
  end

  task automatic push(input bit p, input logic [7:0] r, input logic [7:0] v, input bit accept);
    host_wr   = 1'b1;
    host_port = p;
    host_reg  = r;
    host_val  = v;
    if (accept) begin
      exp_q.push_back(stb_t'{a: {p, 1'b0}, d: r});
      exp_q.push_back(stb_t'{a: {p, 1'b1}, d: v});
    end
    @(posedge clk);
    #1;
    host_wr = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cs_n !== 1'b1) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    report("drain", n < budget, exp_q.size(), 0);
    busy_rand_en = 1'b0;
    idle_cycles(60);
  endtask

  task automatic rand_pushes(input int n, input int maxgap);
    int w;
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (!host_ready && w < 2000) begin
        @(posedge clk);
        #1;
        w++;
      end
      push(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b1);
      idle_cycles($urandom_range(0, maxgap));
    end
  endtask

  initial begin
    int s, w;
    rst_n = 1'b0; host_wr = 1'b0; host_port = 1'b0; host_reg = '0; host_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    report("rst_cs_n", cs_n === 1'b1, int'(cs_n), 1);
    report("rst_wr_n", wr_n === 1'b1, int'(wr_n), 1);
    report("rst_addr", addr === 2'd0, int'(addr), 0);
    report("rst_din", din === 8'd0, int'(din), 0);
    report("rst_level", level === '0, int'(level), 0);
    report("rst_ovf", ovf === 1'b0, int'(ovf), 0);
    report("rst_host_ready", host_ready === 1'b1, int'(host_ready), 1);

    // Release, then push sampled on the second edge after release
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(1'b1, 8'hA4, 8'h3C, 1'b1);
    report("push_second_edge_after_release", level == 1, int'(level), 1);
    cen_run = 1'b1;
    wait_drain(500);

    // Push-to-strobe latency from an idle, empty queue
    push(1'b0, 8'h28, 8'hF0, 1'b1);
    report("no_strobe_at_push_edge", cs_n === 1'b1, int'(cs_n), 1);
    @(posedge clk);
    #1;
    report("cs_low_two_edges_after_push", cs_n === 1'b0, int'(cs_n), 0);
    wait_drain(500);

    busy_rand_en = 1'b1;
    rand_pushes(25, 14);
    wait_drain(3000);

    // cen at 1-of-3: pushes still accepted every clk
    cen_div = 3;
    for (int i = 0; i < 5; i++) push(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b1);
    report("burst_level_cen_div3", level == 4, int'(level), 4);
    report("burst_no_ovf", ovf === 1'b0, int'(ovf), 0);
    busy_rand_en = 1'b1;
    rand_pushes(6, 30);
    wait_drain(3000);
    cen_div = 1;
    idle_cycles(10);

    // Overflow with the chip stuck busy
    busy_force = 1'b1;
    for (int i = 0; i < 17; i++) push(1'(i), 8'(i), 8'(8'hC0 + i), 1'b1);
    report("full_level", level == DEPTH, int'(level), DEPTH);
    report("full_host_ready", host_ready === 1'b0, int'(host_ready), 0);
    report("full_no_ovf_yet", ovf === 1'b0, int'(ovf), 0);
    push(1'b1, 8'hEE, 8'hEE, 1'b0);
    report("drop_sets_ovf", ovf === 1'b1, int'(ovf), 1);
    report("drop_keeps_level", level == DEPTH, int'(level), DEPTH);
    s = nstb;
    idle_cycles(50);
    report("no_strobe_while_busy", nstb == s, nstb - s, 0);
    busy_force = 1'b0;
    @(posedge clk);
    #1;
    report("busy_fall_plus1_idle", cs_n === 1'b1, int'(cs_n), 1);
    @(posedge clk);
    #1;
    report("busy_fall_plus2_astb", cs_n === 1'b0, int'(cs_n), 0);
    wait_drain(1000);

    // Asynchronous reset in the middle of a data strobe
    for (int i = 0; i < 3; i++) push(1'b0, 8'(8'h30 + i), 8'(8'h50 + i), 1'b1);
    w = 0;
    while (!(cs_n === 1'b0 && addr[0] === 1'b1) && w < 200) begin
      @(negedge clk);
      w++;
    end
    report("reached_d_strobe", w < 200, w, 0);
    #2;
    rst_n = 1'b0;
    #1;
    report("async_rst_cs_n", cs_n === 1'b1, int'(cs_n), 1);
    report("async_rst_wr_n", wr_n === 1'b1, int'(wr_n), 1);
    report("async_rst_level", level == 0, int'(level), 0);
    report("async_rst_ovf", ovf === 1'b0, int'(ovf), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    s = nstb;
    idle_cycles(50);
    report("no_strobe_after_reset", nstb == s, nstb - s, 0);
    report("idle_after_reset_cs_n", cs_n === 1'b1, int'(cs_n), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
